// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants for the 800x600 pixel path
package vga_pkg;

  localparam int COLOR_W    = 9;
  localparam int ADDR_W     = 10;
  localparam int BLOCK_SIZE = 25;
  localparam int DEPTH      = BLOCK_SIZE * BLOCK_SIZE;
  localparam int CNT_W      = 16;

  localparam logic [COLOR_W-1:0] KEY_COLOR = 9'h1FF;
  localparam logic [COLOR_W-1:0] BG_COLOR  = 9'h000;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-low here
  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int R_MSB = 8;
  localparam int R_LSB = 6;
  localparam int G_MSB = 5;
  localparam int G_LSB = 3;
  localparam int B_MSB = 2;
  localparam int B_LSB = 0;

endpackage

// File: rtl/sprite_ram.sv
// rtl/sprite_ram.sv - single-clock image RAM, one write port, read-first sync read
module sprite_ram #(
  parameter int DEPTH   = 625,
  parameter int COLOR_W = 9,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [COLOR_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [COLOR_W-1:0] o_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [COLOR_W-1:0] r_mem [0:DEPTH-1];

  // Non-blocking read and write on the same edge gives read-first behaviour
  always_ff @(posedge clk) begin
    if (i_wr_en && (i_wr_addr <= LAST_ADDR)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_addr <= LAST_ADDR) begin
      o_rd_data <= r_mem[i_rd_addr];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule

// File: rtl/vga_pixel_mixer.sv
// rtl/vga_pixel_mixer.sv - two-layer sprite/barrier mixer with per-frame collision count
module vga_pixel_mixer
  import vga_pkg::*;
#(
  parameter int                  ADDR_W    = vga_pkg::ADDR_W,
  parameter int                  DEPTH     = vga_pkg::DEPTH,
  parameter int                  COLOR_W   = vga_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0]  BG_COLOR  = vga_pkg::BG_COLOR,
  parameter logic [COLOR_W-1:0]  KEY_COLOR = vga_pkg::KEY_COLOR,
  parameter int                  CNT_W     = vga_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               barrier_en,
  input  logic [ADDR_W-1:0]  barrier_addr,
  input  logic               sprite_en,
  input  logic [ADDR_W-1:0]  sprite_addr,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               collision,
  output logic [CNT_W-1:0]   collision_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic               w_wr_ok;
  logic [COLOR_W-1:0] w_bar_data;
  logic [COLOR_W-1:0] w_spr_data;

  assign w_wr_ok = wr_en & ~reset;

  sprite_ram #(.DEPTH(DEPTH), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) u_barrier_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_ok & ~wr_sel),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (barrier_addr),
    .o_rd_data (w_bar_data)
  );

  sprite_ram #(.DEPTH(DEPTH), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) u_sprite_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_ok & wr_sel),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (sprite_addr),
    .o_rd_data (w_spr_data)
  );

  // S0 state: control travels alongside the RAM read that is in flight
  logic r0_active;
  logic r0_hs;
  logic r0_vs;
  logic r0_bar_ok;
  logic r0_spr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_active <= 1'b0;
      r0_hs     <= 1'b1;
      r0_vs     <= 1'b1;
      r0_bar_ok <= 1'b0;
      r0_spr_ok <= 1'b0;
    end else begin
      r0_active <= active_in;
      r0_hs     <= hsync_in;
      r0_vs     <= vsync_in;
      r0_bar_ok <= barrier_en & (barrier_addr <= LAST_ADDR);
      r0_spr_ok <= sprite_en & (sprite_addr <= LAST_ADDR);
    end
  end

  logic               w_bar_opq;
  logic               w_spr_opq;
  logic               w_coll;
  logic [COLOR_W-1:0] w_rgb;
  logic               w_frame_edge;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_sum;

  always_comb begin
    w_bar_opq = r0_bar_ok & (w_bar_data != KEY_COLOR);
    w_spr_opq = r0_spr_ok & (w_spr_data != KEY_COLOR);
    w_coll    = r0_active & w_bar_opq & w_spr_opq;
    w_rgb     = BG_COLOR;
    if (!r0_active) begin
      w_rgb = '0;
    end else if (w_spr_opq) begin
      w_rgb = w_spr_data;
    end else if (w_bar_opq) begin
      w_rgb = w_bar_data;
    end
    // vsync_out holds the previous S1 vsync, so this is the falling edge in S1
    w_frame_edge = vsync_out & ~r0_vs;
    w_count_sum  = r_count;
    if (w_coll && (r_count != {CNT_W{1'b1}})) begin
      w_count_sum = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out        <= '0;
      hsync_out      <= 1'b1;
      vsync_out      <= 1'b1;
      collision      <= 1'b0;
      collision_last <= '0;
      r_count        <= '0;
    end else begin
      rgb_out   <= w_rgb;
      hsync_out <= r0_hs;
      vsync_out <= r0_vs;
      collision <= w_coll;
      if (w_frame_edge) begin
        collision_last <= w_count_sum;
        r_count        <= CNT_W'(w_coll);
      end else begin
        r_count <= w_count_sum;
      end
    end
  end

endmodule
